// File: rtl/tinyqv_lsu_pkg.sv
// Shared definitions for the TinyQV load/store unit: mem_op size codes,
// LSU state encoding and the lane/alignment helpers used by the datapath.
package tinyqv_lsu_pkg;

  // mem_op[1:0] access size encodings
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RWAIT   = 3'd2,
    ST_ALIGN   = 3'd3,
    ST_DELIVER = 3'd4
  } lsu_state_t;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always fine.
  // The reserved size code 2'b11 is treated as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return lane[0];
      default:    return (lane != 2'b00);
    endcase
  endfunction

  // Byte enables for a write of the given size at byte lane 'lane'.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_SIZE_B: return 4'b0001 << lane;
      MEM_SIZE_H: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  // Write data replicated across all lanes so the byte enables pick the slot.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sr);
    case (size)
      MEM_SIZE_B: return {4{sr[7:0]}};
      MEM_SIZE_H: return {2{sr[15:0]}};
      default:    return sr;
    endcase
  endfunction

  // Move the addressed byte of a read word down to bit 0.
  function automatic logic [31:0] align_rdata(input logic [31:0] rdata, input logic [1:0] lane);
    return rdata >> {lane, 3'b000};
  endfunction

endpackage

// File: rtl/tinyqv_lsu.sv
// TinyQV load/store unit: converts the core's nibble-serial store data and
// address into a single 32-bit bus transaction, and streams load data back
// to the core as eight nibbles starting at counter==0. One access in flight.
import tinyqv_lsu_pkg::*;

module tinyqv_lsu #(
  parameter int ADDR_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2:0]           counter,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           mem_op,
  input  logic                 address_ready,
  input  logic [ADDR_BITS-1:0] addr_out,
  input  logic [3:0]           data_out,
  output logic [3:0]           data_in,
  output logic                 load_data_ready,
  output logic                 busy,
  output logic                 misaligned,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-3:0] mem_addr,
  output logic [3:0]           mem_wmask,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata
);

  lsu_state_t           state_q, state_d;
  logic [31:0]          sr_q, sr_d;          // store capture / load delivery shifter
  logic [ADDR_BITS-3:0] addr_q, addr_d;      // word address of the access
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic [1:0]           lane_q, lane_d;      // byte offset within the word
  logic                 misaligned_q, misaligned_d;

  // The signed/unsigned bit only matters to the core, which does the extension.
  logic unused_signed_bit;
  assign unused_signed_bit = mem_op[2];

  logic in_req;
  logic in_deliver;
  assign in_req     = (state_q == ST_REQ);
  assign in_deliver = (state_q == ST_DELIVER);

  // State register and datapath flops; reset returns to IDLE mid-access.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state and shift-register control for the access sequence.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    lane_d       = lane_q;
    misaligned_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Store data arrives LSB nibble first; after eight shifts (the last on
        // the address_ready edge) the register holds rs2 exactly.
        if (is_store) begin
          sr_d = {data_out, sr_q[31:4]};
        end
        if (address_ready && (is_load || is_store)) begin
          addr_d = addr_out[ADDR_BITS-1:2];
          we_d   = is_store;
          size_d = mem_op[1:0];
          lane_d = addr_out[1:0];
          if (is_misaligned(mem_op[1:0], addr_out[1:0])) begin
            misaligned_d = 1'b1;
            // A misaligned load still hands the core eight (zero) nibbles so
            // its sequencing is unchanged; a misaligned store is just dropped.
            if (!is_store) begin
              sr_d    = '0;
              state_d = ST_ALIGN;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d = ST_IDLE;
          end else if (mem_rvalid) begin
            // Read data returned in the same clock as the accept.
            sr_d    = align_rdata(mem_rdata, lane_q);
            state_d = ST_ALIGN;
          end else begin
            state_d = ST_RWAIT;
          end
        end
      end

      ST_RWAIT: begin
        if (mem_rvalid) begin
          sr_d    = align_rdata(mem_rdata, lane_q);
          state_d = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        // Leave on counter==7 so the first nibble lines up with counter==0.
        if (counter == 3'd7) begin
          state_d = ST_DELIVER;
        end
      end

      ST_DELIVER: begin
        sr_d = {4'b0000, sr_q[31:4]};
        // Entered at counter==0, so counter==7 marks the eighth nibble.
        if (counter == 3'd7) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus side: request and write fields only while in REQ, stable throughout.
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wmask = (in_req && we_q) ? lane_mask(size_q, lane_q) : 4'b0000;
  assign mem_wdata = (in_req && we_q) ? lane_wdata(size_q, sr_q) : 32'h0000_0000;

  // Core side: nibble stream, stall and misalignment report.
  assign data_in         = in_deliver ? sr_q[3:0] : 4'b0000;
  assign load_data_ready = in_deliver;
  assign busy            = (state_q != ST_IDLE);
  assign misaligned      = misaligned_q;

endmodule
